instruction_assembler: RTL and testbench
========================================

INSTRUCTION_ASSEMBLER -- requirements
Module: instruction_assembler

Interface
REQ-001 Parameter BYTE_W, default 8, SHALL set the width of one ROM byte.
REQ-002 Parameter MAX_BYTES, default 3, SHALL set the maximum instruction length in bytes; legal range 1..4.
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 flush  input  1  SHALL be a synchronous abort of the instruction in progress, e.g. on a jump.
REQ-006 rom_byte  input  BYTE_W  SHALL be the fetched byte.
REQ-007 byte_valid  input  1  SHALL qualify rom_byte.
REQ-008 byte_ready  output  1  SHALL indicate that the block accepts a byte this cycle.
REQ-009 opcode_len  input  3  SHALL be the external decoder's length for the current rom_byte; it is sampled only on an opcode byte.
REQ-010 IR  output  MAX_BYTES*BYTE_W  SHALL hold the assembled instruction.
REQ-011 ir_len  output  3  SHALL give the byte count of the held instruction.
REQ-012 ir_valid  output  1  SHALL flag a complete instruction in IR.
REQ-013 ir_ready  input  1  SHALL be the consumer's acceptance of IR.
REQ-014 byte_count  output  3  SHALL give the number of bytes collected so far.

Function
REQ-015 The block SHALL implement three states: EMPTY, COLLECT and HOLD.
REQ-016 A byte SHALL be accepted when byte_valid and byte_ready are both 1 at a rising edge.
REQ-017 byte_ready SHALL be 1 in EMPTY and COLLECT, and 0 in HOLD.
REQ-018 EMPTY, accepted byte:
- the byte is the opcode and SHALL be written to IR[MAX_BYTES*BYTE_W-1 -: BYTE_W] (most significant slot);
- all other slots SHALL be cleared to 0;
- byte_count SHALL become 1;
- opcode_len SHALL be latched as the target length.
REQ-019 Target length clamping: an opcode_len of 0 SHALL be treated as 1; a value above MAX_BYTES SHALL be treated as MAX_BYTES.
REQ-020 COLLECT, accepted byte number k (k = 2..target):
- it SHALL be written to the k-th slot counting down from the most significant slot;
- byte_count SHALL increment.
REQ-021 When byte_count reaches the target length on an accepted byte, the next state SHALL be HOLD.
- In HOLD: ir_valid = 1 and ir_len = target.
- The transition SHALL come directly from EMPTY when the target is 1.
- Otherwise the next state SHALL be COLLECT.
REQ-022 Latency: ir_valid SHALL rise in the cycle following acceptance of the final byte.
REQ-023 HOLD with ir_ready = 1:
- the next state SHALL be EMPTY;
- ir_valid SHALL become 0;
- byte_count SHALL become 0;
- IR and ir_len SHALL retain their values until the next opcode byte is accepted.
REQ-024 HOLD with ir_ready = 0: IR, ir_len and ir_valid SHALL hold stable.
REQ-025 flush = 1 SHALL take priority over all other inputs, in any state:
- the next state SHALL be EMPTY;
- IR, ir_len and byte_count SHALL become 0;
- ir_valid SHALL become 0;
- a byte presented in the same cycle SHALL be discarded.
REQ-026 byte_valid = 0 SHALL leave all state unchanged, with no timeout.
REQ-027 IR SHALL never be modified by bytes arriving while in HOLD; those bytes are not accepted because byte_ready = 0.

Reset
REQ-028 While reset = 1, regardless of clock, the block SHALL be held as follows:
- state = EMPTY;
- IR = 0, ir_len = 0, ir_valid = 0, byte_count = 0;
- byte_ready = 1 once reset is released.
REQ-029 Reset asserted in the middle of an instruction SHALL discard the partial instruction without producing ir_valid.

Verification
REQ-030 Scenario: 1-byte instruction (MAX_BYTES=3). Stimulus: byte 0x04, opcode_len = 1, then ir_ready = 1. Required: next cycle IR = 0x040000, ir_len = 1, ir_valid = 1; the cycle after ir_ready, ir_valid = 0.
REQ-031 Scenario: 3-byte instruction. Stimulus: bytes 0x02, 0x12, 0x34 with opcode_len = 3. Required: IR = 0x021234, ir_len = 3, and ir_valid high exactly one cycle after 0x34 is accepted.
REQ-032 Scenario: stall and backpressure. Stimulus: a 2-byte instruction 0x74, 0x55 with a 3-cycle byte_valid gap between the bytes, then ir_ready held 0 for 4 cycles. Required: IR = 0x745500; ir_valid held; byte_ready = 0 throughout HOLD.
REQ-033 Scenario: flush. Stimulus: flush asserted after 0x90, 0x12 of a 3-byte instruction, together with a byte on that cycle. Required: IR = 0, byte_count = 0, no ir_valid; the next byte is treated as an opcode.
REQ-034 Scenario: length clamping and async reset. Stimulus: opcode_len = 0 on byte 0xA5, then opcode_len = 7 on byte 0x80 followed by 2 more bytes; then reset pulsed between clock edges mid-collect. Required: the first instruction has ir_len = 1; the second has ir_len = 3; all outputs are 0 immediately on reset, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_assembler.sv
// Assembles variable-length instructions from a byte stream into IR.
// Hands each complete instruction to a consumer with a valid/ready handshake.
module instruction_assembler #(
  parameter int BYTE_W    = 8,
  parameter int MAX_BYTES = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [BYTE_W-1:0]           rom_byte,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  input  logic [2:0]                  opcode_len,
  output logic [MAX_BYTES*BYTE_W-1:0] IR,
  output logic [2:0]                  ir_len,
  output logic                        ir_valid,
  input  logic                        ir_ready,
  output logic [2:0]                  byte_count
);

  localparam int IR_W = MAX_BYTES * BYTE_W;
  localparam logic [2:0] MAX_L = 3'(MAX_BYTES);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t            r_state;
  logic [IR_W-1:0]   r_ir;
  logic [2:0]        r_tgt;
  logic [2:0]        r_cnt;
  logic              r_valid;

  logic [2:0]        w_tgt;
  logic [2:0]        w_slot;
  logic [2:0]        w_cnt_nx;
  logic              w_acc;

  // Length 0 means a bare opcode; anything longer than IR can hold is capped.
  always_comb begin
    w_tgt = opcode_len;
    if (opcode_len == 3'd0) w_tgt = 3'd1;
    else if (opcode_len > MAX_L) w_tgt = MAX_L;
  end

  assign w_acc    = byte_valid && byte_ready;
  assign w_cnt_nx = r_cnt + 3'd1;
  assign w_slot   = MAX_L - 3'd1 - r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_ir    <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_ir    <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_ir                      <= '0;
            r_ir[IR_W-1 -: BYTE_W]    <= rom_byte;
            r_cnt                     <= 3'd1;
            r_tgt                     <= w_tgt;
            if (w_tgt == 3'd1) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
            end else begin
              r_state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (w_acc) begin
            for (int s = 0; s < MAX_BYTES; s++) begin
              if (3'(s) == w_slot) r_ir[s*BYTE_W +: BYTE_W] <= rom_byte;
            end
            r_cnt <= w_cnt_nx;
            if (w_cnt_nx == r_tgt) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (ir_ready) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_cnt   <= 3'd0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = (r_state != HOLD);
  assign IR         = r_ir;
  assign ir_len     = r_tgt;
  assign ir_valid   = r_valid;
  assign byte_count = r_cnt;

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed bench for instruction_assembler: per-cycle vector table plus
// a hand-written asynchronous reset sequence.
module tb_instruction_assembler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  rom_byte = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [2:0]  opcode_len = '0;
  logic [23:0] IR;
  logic [2:0]  ir_len;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [2:0]  byte_count;

  int n_run = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  instruction_assembler #(.BYTE_W(8), .MAX_BYTES(3)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .rom_byte(rom_byte), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .opcode_len(opcode_len), .IR(IR), .ir_len(ir_len),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .byte_count(byte_count)
  );

  typedef struct {
    string      name;
    logic       fl;
    logic [7:0] b;
    logic       bv;
    logic [2:0] ol;
    logic       rdy;
    logic [23:0] e_ir;
    logic       chk_len;
    logic [2:0] e_len;
    logic       e_val;
    logic [2:0] e_cnt;
    logic       e_brdy;
  } vec_t;

  vec_t v[$];

  task automatic check(input string nm, input logic [23:0] e_ir,
                       input logic chk_len, input logic [2:0] e_len,
                       input logic e_val, input logic [2:0] e_cnt,
                       input logic e_brdy);
    logic ok;
    ok = (IR === e_ir) && (ir_valid === e_val) &&
         (byte_count === e_cnt) && (byte_ready === e_brdy) &&
         (!chk_len || ir_len === e_len);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got IR=%h len=%0d val=%b cnt=%0d brdy=%b, want IR=%h len=%0d(chk=%b) val=%b cnt=%0d brdy=%b",
               nm, IR, ir_len, ir_valid, byte_count, byte_ready,
               e_ir, e_len, chk_len, e_val, e_cnt, e_brdy);
    end
  endtask

  task automatic add(input string nm, input logic fl, input logic [7:0] b,
                     input logic bv, input logic [2:0] ol, input logic rdy,
                     input logic [23:0] e_ir, input logic cl,
                     input logic [2:0] el, input logic ev,
                     input logic [2:0] ec, input logic eb);
    vec_t t;
    t.name = nm; t.fl = fl; t.b = b; t.bv = bv; t.ol = ol; t.rdy = rdy;
    t.e_ir = e_ir; t.chk_len = cl; t.e_len = el; t.e_val = ev;
    t.e_cnt = ec; t.e_brdy = eb;
    v.push_back(t);
  endtask

  task automatic drive(input logic fl, input logic [7:0] b, input logic bv,
                       input logic [2:0] ol, input logic rdy);
    flush = fl; rom_byte = b; byte_valid = bv;
    opcode_len = ol; ir_ready = rdy;
  endtask

  initial begin
    //   name        fl  byte  bv ol  rdy  IR         cl len val cnt brdy
    add("one_b",     0, 8'h04, 1, 1, 0, 24'h040000, 1, 1, 1, 1, 0);
    add("one_hold",  0, 8'h00, 0, 1, 0, 24'h040000, 1, 1, 1, 1, 0);
    add("one_take",  0, 8'h00, 0, 0, 1, 24'h040000, 1, 1, 0, 0, 1);
    add("three_b0",  0, 8'h02, 1, 3, 0, 24'h020000, 0, 0, 0, 1, 1);
    add("three_b1",  0, 8'h12, 1, 0, 0, 24'h021200, 0, 0, 0, 2, 1);
    add("three_b2",  0, 8'h34, 1, 0, 0, 24'h021234, 1, 3, 1, 3, 0);
    add("three_tk",  0, 8'h00, 0, 0, 1, 24'h021234, 1, 3, 0, 0, 1);
    add("stall_b0",  0, 8'h74, 1, 2, 0, 24'h740000, 0, 0, 0, 1, 1);
    add("gap1",      0, 8'hEE, 0, 5, 0, 24'h740000, 0, 0, 0, 1, 1);
    add("gap2",      0, 8'hEE, 0, 5, 0, 24'h740000, 0, 0, 0, 1, 1);
    add("gap3",      0, 8'hEE, 0, 5, 0, 24'h740000, 0, 0, 0, 1, 1);
    add("stall_b1",  0, 8'h55, 1, 0, 0, 24'h745500, 1, 2, 1, 2, 0);
    add("bp1",       0, 8'hFF, 1, 1, 0, 24'h745500, 1, 2, 1, 2, 0);
    add("bp2",       0, 8'hFF, 1, 1, 0, 24'h745500, 1, 2, 1, 2, 0);
    add("bp3",       0, 8'hFF, 1, 1, 0, 24'h745500, 1, 2, 1, 2, 0);
    add("bp4",       0, 8'hFF, 1, 1, 0, 24'h745500, 1, 2, 1, 2, 0);
    add("bp_take",   0, 8'h00, 0, 0, 1, 24'h745500, 1, 2, 0, 0, 1);
    add("fl_b0",     0, 8'h90, 1, 3, 0, 24'h900000, 0, 0, 0, 1, 1);
    add("fl_b1",     0, 8'h12, 1, 0, 0, 24'h901200, 0, 0, 0, 2, 1);
    add("flush",     1, 8'h56, 1, 0, 0, 24'h000000, 1, 0, 0, 0, 1);
    add("fl_opc",    0, 8'h11, 1, 1, 0, 24'h110000, 1, 1, 1, 1, 0);
    add("fl_take",   0, 8'h00, 0, 0, 1, 24'h110000, 1, 1, 0, 0, 1);
    add("clamp0",    0, 8'hA5, 1, 0, 0, 24'hA50000, 1, 1, 1, 1, 0);
    add("clamp0_tk", 0, 8'h00, 0, 0, 1, 24'hA50000, 1, 1, 0, 0, 1);
    add("clamp7_b0", 0, 8'h80, 1, 7, 0, 24'h800000, 0, 0, 0, 1, 1);
    add("clamp7_b1", 0, 8'h01, 1, 0, 1, 24'h800100, 0, 0, 0, 2, 1);
    add("clamp7_b2", 0, 8'h02, 1, 0, 0, 24'h800102, 1, 3, 1, 3, 0);
    add("clamp7_tk", 0, 8'h00, 0, 0, 1, 24'h800102, 1, 3, 0, 0, 1);
    add("hold_b",    0, 8'hA7, 1, 1, 0, 24'hA70000, 1, 1, 1, 1, 0);
    add("hold_fl",   1, 8'h00, 0, 0, 0, 24'h000000, 1, 0, 0, 0, 1);

    #1 reset = 1'b1;
    #1 check("reset_state", 24'h0, 1, 3'd0, 0, 3'd0, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    check("post_reset", 24'h0, 1, 3'd0, 0, 3'd0, 1);

    foreach (v[i]) begin
      drive(v[i].fl, v[i].b, v[i].bv, v[i].ol, v[i].rdy);
      @(posedge clock); #1;
      check(v[i].name, v[i].e_ir, v[i].chk_len, v[i].e_len,
            v[i].e_val, v[i].e_cnt, v[i].e_brdy);
    end

    drive(0, 8'h33, 1, 3, 0);
    @(posedge clock); #1;
    drive(0, 8'h44, 1, 0, 0);
    @(posedge clock); #1;
    check("ar_partial", 24'h334400, 0, 3'd0, 0, 3'd2, 1);
    drive(0, 8'h66, 1, 0, 0);
    #2 reset = 1'b1;
    #1 check("ar_async", 24'h0, 1, 3'd0, 0, 3'd0, 1);
    @(posedge clock); #1;
    check("ar_held", 24'h0, 1, 3'd0, 0, 3'd0, 1);
    reset = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    @(posedge clock); #1;
    check("ar_novalid", 24'h0, 1, 3'd0, 0, 3'd0, 1);
    drive(0, 8'h5C, 1, 1, 0);
    @(posedge clock); #1;
    check("ar_opcode", 24'h5C0000, 1, 3'd1, 1, 3'd1, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
